// File: rtl/ecc_31_rd_chk.sv
// ecc_31_rd_chk: registered read-side stage behind the 31-bit SECDED decoder.
// Buffers corrected beats in a 2-entry skid buffer and counts single-bit and
// double-bit errors in saturating counters. It keeps a first-error capture
// register and drives an interrupt level for the FIFO status logic.
module ecc_31_rd_chk #(
  parameter int DATA_WIDTH  = 31,
  parameter int ADDR_WIDTH  = 6,
  parameter int CNT_WIDTH   = 8,
  parameter int SBIT_THRESH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_sbit,
  input  logic                  in_dbit,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            out_err,
  output logic [CNT_WIDTH-1:0]  sbit_cnt,
  output logic [CNT_WIDTH-1:0]  dbit_cnt,
  output logic                  err_vld,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic [1:0]            err_type,
  input  logic                  clr,
  output logic                  irq
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] THRESH   = CNT_WIDTH'(SBIT_THRESH);

  // A beat flagged with both errors is reported as double-bit only.
  function automatic logic [1:0] err_tag(input logic sbit, input logic dbit);
    logic [1:0] tag;
    if (dbit) begin
      tag = 2'b10;
    end else if (sbit) begin
      tag = 2'b01;
    end else begin
      tag = 2'b00;
    end
    return tag;
  endfunction

  // Saturating increment: the counter sticks at all-ones.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] val);
    logic [CNT_WIDTH-1:0] res;
    if (val == CNT_MAX) begin
      res = CNT_MAX;
    end else begin
      res = val + CNT_ONE;
    end
    return res;
  endfunction

  buf_state_t            state_r, state_s;
  logic [DATA_WIDTH-1:0] head_data_r, head_data_s;
  logic [1:0]            head_err_r, head_err_s;
  logic [DATA_WIDTH-1:0] skid_data_r, skid_data_s;
  logic [1:0]            skid_err_r, skid_err_s;
  logic                  in_rdy_r;
  logic                  out_vld_r;

  logic [CNT_WIDTH-1:0]  sbit_cnt_r, sbit_cnt_s;
  logic [CNT_WIDTH-1:0]  dbit_cnt_r, dbit_cnt_s;
  logic                  err_vld_r, err_vld_s;
  logic [ADDR_WIDTH-1:0] err_addr_r, err_addr_s;
  logic [1:0]            err_type_r, err_type_s;
  logic                  irq_r;

  logic                  accept_s;
  logic                  drain_s;
  logic [1:0]            tag_s;

  assign accept_s = in_vld & in_rdy_r;
  assign drain_s  = out_vld_r & out_rdy;
  assign tag_s    = err_tag(in_sbit, in_dbit);

  // Skid-buffer next state: head feeds the output, skid holds the second beat.
  always_comb begin
    state_s     = state_r;
    head_data_s = head_data_r;
    head_err_s  = head_err_r;
    skid_data_s = skid_data_r;
    skid_err_s  = skid_err_r;
    case (state_r)
      ST_EMPTY: begin
        if (accept_s) begin
          state_s     = ST_ONE;
          head_data_s = in_data;
          head_err_s  = tag_s;
        end else begin
          state_s = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (accept_s && !drain_s) begin
          state_s     = ST_TWO;
          skid_data_s = in_data;
          skid_err_s  = tag_s;
        end else if (accept_s && drain_s) begin
          state_s     = ST_ONE;
          head_data_s = in_data;
          head_err_s  = tag_s;
        end else if (drain_s) begin
          state_s = ST_EMPTY;
        end else begin
          state_s = ST_ONE;
        end
      end
      ST_TWO: begin
        if (drain_s) begin
          state_s     = ST_ONE;
          head_data_s = skid_data_r;
          head_err_s  = skid_err_r;
        end else begin
          state_s = ST_TWO;
        end
      end
      default: begin
        state_s = ST_EMPTY;
      end
    endcase
  end

  // Buffer registers; ready and valid are registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_EMPTY;
      head_data_r <= {DATA_WIDTH{1'b0}};
      head_err_r  <= 2'b00;
      skid_data_r <= {DATA_WIDTH{1'b0}};
      skid_err_r  <= 2'b00;
      in_rdy_r    <= 1'b1;
      out_vld_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      head_data_r <= head_data_s;
      head_err_r  <= head_err_s;
      skid_data_r <= skid_data_s;
      skid_err_r  <= skid_err_s;
      in_rdy_r    <= (state_s != ST_TWO);
      out_vld_r   <= (state_s != ST_EMPTY);
    end
  end

  // Counter and capture update: clear first, then apply the accepted beat.
  always_comb begin
    sbit_cnt_s = sbit_cnt_r;
    dbit_cnt_s = dbit_cnt_r;
    err_vld_s  = err_vld_r;
    err_addr_s = err_addr_r;
    err_type_s = err_type_r;
    if (clr) begin
      sbit_cnt_s = CNT_ZERO;
      dbit_cnt_s = CNT_ZERO;
      err_vld_s  = 1'b0;
      err_addr_s = {ADDR_WIDTH{1'b0}};
      err_type_s = 2'b00;
    end else begin
      sbit_cnt_s = sbit_cnt_r;
    end
    if (accept_s && (tag_s != 2'b00)) begin
      if (tag_s == 2'b10) begin
        dbit_cnt_s = sat_inc(dbit_cnt_s);
      end else begin
        sbit_cnt_s = sat_inc(sbit_cnt_s);
      end
      // Load on the first error, or upgrade a held single-bit to double-bit once.
      if (!err_vld_s || ((err_type_s == 2'b01) && (tag_s == 2'b10))) begin
        err_vld_s  = 1'b1;
        err_addr_s = in_addr;
        err_type_s = tag_s;
      end else begin
        err_vld_s = err_vld_s;
      end
    end else begin
      err_vld_s = err_vld_s;
    end
  end

  // Error counters, capture register and the interrupt level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sbit_cnt_r <= CNT_ZERO;
      dbit_cnt_r <= CNT_ZERO;
      err_vld_r  <= 1'b0;
      err_addr_r <= {ADDR_WIDTH{1'b0}};
      err_type_r <= 2'b00;
      irq_r      <= 1'b0;
    end else begin
      sbit_cnt_r <= sbit_cnt_s;
      dbit_cnt_r <= dbit_cnt_s;
      err_vld_r  <= err_vld_s;
      err_addr_r <= err_addr_s;
      err_type_r <= err_type_s;
      // Follows the updated counters, so it rises one cycle after the count.
      irq_r      <= (dbit_cnt_r != CNT_ZERO) | (sbit_cnt_r >= THRESH);
    end
  end

  assign in_rdy   = in_rdy_r;
  assign out_vld  = out_vld_r;
  assign out_data = head_data_r;
  assign out_err  = head_err_r;
  assign sbit_cnt = sbit_cnt_r;
  assign dbit_cnt = dbit_cnt_r;
  assign err_vld  = err_vld_r;
  assign err_addr = err_addr_r;
  assign err_type = err_type_r;
  assign irq      = irq_r;

endmodule

// File: tb/tb_ecc_31_rd_chk.sv
// Self-checking bench for ecc_31_rd_chk: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_ecc_31_rd_chk;
  localparam int DW = 31;
  localparam int AW = 6;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_vld, in_rdy, in_sbit, in_dbit, out_vld, out_rdy, err_vld, clr, irq;
  logic [DW-1:0] in_data, out_data;
  logic [AW-1:0] in_addr, err_addr;
  logic [1:0]    out_err, err_type;
  logic [CW-1:0] sbit_cnt, dbit_cnt;

  ecc_31_rd_chk #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW), .SBIT_THRESH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
    .in_sbit(in_sbit), .in_dbit(in_dbit), .in_addr(in_addr), .out_vld(out_vld),
    .out_rdy(out_rdy), .out_data(out_data), .out_err(out_err), .sbit_cnt(sbit_cnt),
    .dbit_cnt(dbit_cnt), .err_vld(err_vld), .err_addr(err_addr), .err_type(err_type),
    .clr(clr), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: FIFO of {tag,data}, plain integer counters.
  logic [DW+1:0] mq[$];
  int            m_scnt, m_dcnt;
  logic          m_ev, m_irq;
  logic [AW-1:0] m_addr;
  logic [1:0]    m_type;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_scnt = 0; m_dcnt = 0; m_ev = 1'b0; m_addr = '0; m_type = 2'b00; m_irq = 1'b0;
  endtask

  task automatic check_all();
    chk("in_rdy", in_rdy, mq.size() < 2);
    chk("out_vld", out_vld, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("out_data", out_data, mq[0][DW-1:0]);
      chk("out_err", out_err, mq[0][DW+1:DW]);
    end
    chk("sbit_cnt", sbit_cnt, m_scnt);
    chk("dbit_cnt", dbit_cnt, m_dcnt);
    chk("err_vld", err_vld, m_ev);
    chk("err_addr", err_addr, m_addr);
    chk("err_type", err_type, m_type);
    chk("irq", irq, m_irq);
  endtask

  // One clock: drive inputs, advance model at the edge, check at the falling edge.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic s, input logic db,
                       input logic [AW-1:0] a, input logic ordy, input logic c);
    bit         acc, drn;
    logic [1:0] tg;
    in_vld = v; in_data = d; in_sbit = s; in_dbit = db; in_addr = a; out_rdy = ordy; clr = c;
    @(posedge clk);
    acc = v && (mq.size() < 2);
    drn = ordy && (mq.size() > 0);
    tg  = db ? 2'b10 : (s ? 2'b01 : 2'b00);
    m_irq = (m_dcnt != 0) || (m_scnt >= 16);
    if (drn) void'(mq.pop_front());
    if (acc) mq.push_back({tg, d});
    if (c) begin
      m_scnt = 0; m_dcnt = 0; m_ev = 1'b0; m_addr = '0; m_type = 2'b00;
    end
    if (acc && tg == 2'b10) m_dcnt = (m_dcnt < 255) ? m_dcnt + 1 : 255;
    if (acc && tg == 2'b01) m_scnt = (m_scnt < 255) ? m_scnt + 1 : 255;
    if (acc && tg != 2'b00 && (!m_ev || (m_type == 2'b01 && tg == 2'b10))) begin
      m_ev = 1'b1; m_addr = a; m_type = tg;
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst_n = 1'b0; in_vld = 1'b0; in_data = '0; in_sbit = 1'b0; in_dbit = 1'b0;
    in_addr = '0; out_rdy = 1'b0; clr = 1'b0;
    model_reset();
    #1;
    chk("rst_out_vld", out_vld, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_irq", irq, 1'b0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all();
    chk("rst_out_err", out_err, 2'b00);

    // Streaming: data equals address, no errors.
    for (int i = 0; i < 10; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0, AW'(i), 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);

    // Backpressure: three beats offered, two fit, third waits for space.
    cycle(1'b1, DW'(100), 1'b0, 1'b0, AW'(1), 1'b0, 1'b0);
    cycle(1'b1, DW'(101), 1'b0, 1'b0, AW'(2), 1'b0, 1'b0);
    cycle(1'b1, DW'(102), 1'b0, 1'b0, AW'(3), 1'b0, 1'b0);
    chk("bp_hold", out_data, DW'(100));
    chk("bp_rdy", in_rdy, 1'b0);
    cycle(1'b1, DW'(102), 1'b0, 1'b0, AW'(3), 1'b1, 1'b0);
    cycle(1'b1, DW'(102), 1'b0, 1'b0, AW'(3), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);

    // Sixteen single-bit errors, first at address 5.
    for (int i = 0; i < 16; i++) cycle(1'b1, DW'(i + 200), 1'b1, 1'b0, AW'(i + 5), 1'b1, 1'b0);
    chk("sb_cnt16", sbit_cnt, 8'd16);
    chk("sb_addr", err_addr, 6'd5);
    chk("sb_type", err_type, 2'b01);
    chk("sb_irq_pre", irq, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk("sb_irq_post", irq, 1'b1);

    // Clear, then upgrade from single-bit to double-bit exactly once.
    cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
    cycle(1'b1, DW'(300), 1'b1, 1'b0, AW'(3), 1'b1, 1'b0);
    cycle(1'b1, DW'(301), 1'b1, 1'b1, AW'(9), 1'b1, 1'b0);
    cycle(1'b1, DW'(302), 1'b0, 1'b1, AW'(12), 1'b1, 1'b0);
    chk("up_addr", err_addr, 6'd9);
    chk("up_type", err_type, 2'b10);
    chk("up_sbit", sbit_cnt, 8'd1);

    // Saturation of the double-bit counter.
    for (int i = 0; i < 300; i++) cycle(1'b1, DW'(i), 1'b0, 1'b1, AW'(i), 1'b1, 1'b0);
    chk("dsat", dbit_cnt, 8'd255);
    cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk("dsat_hold", dbit_cnt, 8'd255);

    // Clear colliding with an accepted single-bit beat.
    cycle(1'b1, DW'(77), 1'b1, 1'b0, AW'(7), 1'b1, 1'b1);
    chk("col_sbit", sbit_cnt, 8'd1);
    chk("col_dbit", dbit_cnt, 8'd0);
    chk("col_addr", err_addr, 6'd7);
    chk("col_vld", err_vld, 1'b1);

    // Random traffic with random backpressure, errors and rare clears.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), DW'($urandom), 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 15) == 0), AW'($urandom), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 63) == 0));
    end

    // Asynchronous reset while the buffer is full and counters are non-zero.
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, DW'(500), 1'b0, 1'b1, AW'(20), 1'b0, 1'b0);
    cycle(1'b1, DW'(501), 1'b1, 1'b0, AW'(21), 1'b0, 1'b0);
    chk("pre_rst_full", in_rdy, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_vld", out_vld, 1'b0);
    chk("arst_sbit", sbit_cnt, 8'd0);
    chk("arst_dbit", dbit_cnt, 8'd0);
    chk("arst_err_vld", err_vld, 1'b0);
    model_reset();
    in_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all();
    cycle(1'b1, DW'(600), 1'b0, 1'b0, AW'(4), 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
